// File: rtl/store.sv
// store: AXI4 write master that issues queued word stores as single-beat writes.
// Requests enter a small circular FIFO. One AW/W/B transaction is in flight at a time.
// Optional feature macro: STORE_BRESP_ERR_EN. When it is defined, the first non-OKAY
// BRESP sets a sticky O_ERR and records the address of that write in O_ERR_ADDR.
module store #(
    parameter int unsigned C_M_AXI_THREAD_ID_WIDTH = 1,
    parameter int unsigned C_M_AXI_AWUSER_WIDTH    = 1,
    parameter int unsigned C_M_AXI_WUSER_WIDTH     = 4,
    parameter int unsigned C_M_AXI_BUSER_WIDTH     = 1,
    parameter int unsigned QDEPTH_LOG2             = 2
) (
    input  logic                               ACLK,
    input  logic                               ARESETN,
    input  logic [31:0]                        I_ADDR,
    input  logic [31:0]                        I_DATA,
    input  logic [3:0]                         I_STRB,
    input  logic                               I_VALID,
    output logic                               I_READY,
    output logic                               O_BUSY,
    output logic                               O_DONE,
    output logic                               O_ERR,
    output logic [31:0]                        O_ERR_ADDR,
    output logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_AWID,
    output logic [31:0]                        M_AXI_AWADDR,
    output logic [7:0]                         M_AXI_AWLEN,
    output logic [2:0]                         M_AXI_AWSIZE,
    output logic [1:0]                         M_AXI_AWBURST,
    output logic [1:0]                         M_AXI_AWLOCK,
    output logic [3:0]                         M_AXI_AWCACHE,
    output logic [2:0]                         M_AXI_AWPROT,
    output logic [3:0]                         M_AXI_AWQOS,
    output logic [C_M_AXI_AWUSER_WIDTH-1:0]    M_AXI_AWUSER,
    output logic                               M_AXI_AWVALID,
    input  logic                               M_AXI_AWREADY,
    output logic [31:0]                        M_AXI_WDATA,
    output logic [3:0]                         M_AXI_WSTRB,
    output logic                               M_AXI_WLAST,
    output logic [C_M_AXI_WUSER_WIDTH-1:0]     M_AXI_WUSER,
    output logic                               M_AXI_WVALID,
    input  logic                               M_AXI_WREADY,
    input  logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_BID,
    input  logic [1:0]                         M_AXI_BRESP,
    input  logic [C_M_AXI_BUSER_WIDTH-1:0]     M_AXI_BUSER,
    input  logic                               M_AXI_BVALID,
    output logic                               M_AXI_BREADY
);

    localparam int unsigned Depth = 1 << QDEPTH_LOG2;

    typedef enum logic [1:0] {StIdle, StAddr, StResp} state_e;

    state_e                 state_q;
    logic [QDEPTH_LOG2:0]   wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
    logic [QDEPTH_LOG2-1:0] wr_idx, rd_idx;
    logic [29:0]            q_addr [Depth];
    logic [31:0]            q_data [Depth];
    logic [3:0]             q_strb [Depth];
    logic                   full, empty, push, pop, nonempty_d;

    logic [29:0] awaddr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        awvalid_q, wvalid_q, bready_q, aw_done_q, w_done_q, done_q, busy_q;
    logic        aw_fire, w_fire, b_fire, aw_all, w_all;

    assign wr_idx = wr_ptr_q[QDEPTH_LOG2-1:0];
    assign rd_idx = rd_ptr_q[QDEPTH_LOG2-1:0];

    // Extra pointer MSB separates full from empty when the indices match
    assign full  = (wr_ptr_q[QDEPTH_LOG2] != rd_ptr_q[QDEPTH_LOG2]) && (wr_idx == rd_idx);
    assign empty = (wr_ptr_q == rd_ptr_q);

    // A full queue refuses pushes even when a pop happens in the same cycle
    assign push = I_VALID && !full;
    assign pop  = (state_q == StIdle) && !empty;

    assign wr_ptr_d   = wr_ptr_q + {{QDEPTH_LOG2{1'b0}}, push};
    assign rd_ptr_d   = rd_ptr_q + {{QDEPTH_LOG2{1'b0}}, pop};
    assign nonempty_d = (wr_ptr_d != rd_ptr_d);

    assign aw_fire = awvalid_q && M_AXI_AWREADY;
    assign w_fire  = wvalid_q && M_AXI_WREADY;
    assign b_fire  = bready_q && M_AXI_BVALID;
    assign aw_all  = aw_done_q || aw_fire;
    assign w_all   = w_done_q || w_fire;

    // Queue pointers
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Queue storage, written on an accepted push
    always_ff @(posedge ACLK) begin
        if (push) begin
            q_addr[wr_idx] <= I_ADDR[31:2];
            q_data[wr_idx] <= I_DATA;
            q_strb[wr_idx] <= I_STRB;
        end
    end

    // Transaction FSM with registered channel controls, done pulse and busy flag
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q   <= StIdle;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    busy_q <= nonempty_d || pop;
                    if (pop) begin
                        awaddr_q  <= q_addr[rd_idx];
                        wdata_q   <= q_data[rd_idx];
                        wstrb_q   <= q_strb[rd_idx];
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        state_q   <= StAddr;
                    end
                end
                StAddr: begin
                    busy_q    <= 1'b1;
                    aw_done_q <= aw_all;
                    w_done_q  <= w_all;
                    if (aw_fire) awvalid_q <= 1'b0;
                    if (w_fire) wvalid_q <= 1'b0;
                    if (aw_all && w_all) begin
                        bready_q <= 1'b1;
                        state_q  <= StResp;
                    end
                end
                StResp: begin
                    if (b_fire) begin
                        bready_q <= 1'b0;
                        done_q   <= 1'b1;
                        busy_q   <= nonempty_d;
                        state_q  <= StIdle;
                    end else begin
                        busy_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef STORE_BRESP_ERR_EN
    logic        err_q;
    logic [31:0] err_addr_q;
    logic        unused_inputs;

    // Capture only the first non-OKAY response; held until reset
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else if (b_fire && (M_AXI_BRESP != 2'b00) && !err_q) begin
            err_q      <= 1'b1;
            err_addr_q <= {awaddr_q, 2'b00};
        end
    end

    assign O_ERR         = err_q;
    assign O_ERR_ADDR    = err_addr_q;
    assign unused_inputs = ^{I_ADDR[1:0], M_AXI_BID, M_AXI_BUSER};
`else
    logic unused_inputs;

    assign O_ERR         = 1'b0;
    assign O_ERR_ADDR    = '0;
    assign unused_inputs = ^{I_ADDR[1:0], M_AXI_BID, M_AXI_BUSER, M_AXI_BRESP};
`endif

    assign I_READY = !full;
    assign O_BUSY  = busy_q;
    assign O_DONE  = done_q;

    assign M_AXI_AWID    = '0;
    assign M_AXI_AWADDR  = {awaddr_q, 2'b00};
    assign M_AXI_AWLEN   = 8'd0;
    assign M_AXI_AWSIZE  = 3'b010;
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_AWLOCK  = 2'b00;
    assign M_AXI_AWCACHE = 4'b0011;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWQOS   = 4'b0000;
    assign M_AXI_AWUSER  = '0;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WLAST   = wvalid_q;
    assign M_AXI_WUSER   = '0;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;

endmodule
